// File: rtl/muldiv_pkg.sv
// Shared decode constants for the integer execute stage.
// Holds base ALU funct3 codes, RV32M funct3 codes and the muldiv FSM state type.
package muldiv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } md_state_e;

  // rs1 is treated as signed
  function automatic logic f3_sgn1(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_MULHSU) ||
           (f == F3_DIV)  || (f == F3_REM);
  endfunction

  // rs2 is treated as signed
  function automatic logic f3_sgn2(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequential multiplier/divider.
// Multiply: shift-add on {hi,lo}; divide: restoring trial-subtract on {hi,lo}.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_op,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_sh;
  logic [XLEN:0] w_diff;

  assign w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_op} : '0);
  assign w_sh   = {i_hi, i_lo[XLEN-1]};
  assign w_diff = w_sh - {1'b0, i_op};

  // Select the multiply or divide step; borrow means restore
  always_comb begin
    o_hi = w_sum[XLEN:1];
    o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    if (i_is_div) begin
      if (w_diff[XLEN]) begin
        o_hi = w_sh[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b0};
      end else begin
        o_hi = w_diff[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative RV32M multiply/divide unit: FSM, counter and operand registers.
// Magnitudes are iterated one bit per cycle; ITER is expected to equal XLEN.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_op;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_in_ready;
  logic            r_busy;
  logic            r_out_valid;
  logic [XLEN-1:0] r_result;

  logic              w_accept;
  logic              w_div;
  logic              w_s1;
  logic              w_s2;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic              w_dz;
  logic              w_ovf;
  logic [XLEN-1:0]   w_triv;
  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  logic [XLEN-1:0]   w_final;

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign result    = r_result;

  assign w_accept = in_valid & r_in_ready & ~flush;
  assign w_div    = funct3[2];
  assign w_s1     = f3_sgn1(funct3) & src1[XLEN-1];
  assign w_s2     = f3_sgn2(funct3) & src2[XLEN-1];
  assign w_mag1   = w_s1 ? -src1 : src1;
  assign w_mag2   = w_s2 ? -src2 : src2;
  assign w_dz     = w_div & (src2 == '0);
  assign w_ovf    = w_div & f3_sgn1(funct3) &
                    (src1 == SMIN) & (src2 == '1);

  // Divide-by-zero and signed overflow finish without iterating
  always_comb begin
    w_triv = '1;
    if (w_dz)
      w_triv = funct3[1] ? src1 : '1;
    else if (w_ovf)
      w_triv = funct3[1] ? '0 : SMIN;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_is_div (r_f3[2]),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_op     (r_op),
    .o_hi     (w_hi),
    .o_lo     (w_lo)
  );

  assign w_prod   = {w_hi, w_lo};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_q      = r_neg_q ? -w_lo : w_lo;
  assign w_r      = r_neg_r ? -w_hi : w_hi;

  // Sign-correct the final step's value into the architectural result
  always_comb begin
    w_final = w_prod_s[2*XLEN-1:XLEN];
    if (r_f3[2])
      w_final = r_f3[1] ? w_r : w_q;
    else if (r_f3 == F3_MUL)
      w_final = w_prod_s[XLEN-1:0];
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_f3        <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_op        <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_f3       <= funct3;
            r_hi       <= '0;
            r_lo       <= w_div ? w_mag1 : w_mag2;
            r_op       <= w_div ? w_mag2 : w_mag1;
            r_neg_q    <= w_s1 ^ w_s2;
            r_neg_r    <= w_s1;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_dz | w_ovf) begin
              r_state     <= ST_DONE;
              r_result    <= w_triv;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_CALC;
              r_cnt   <= CW'(ITER - 1);
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_hi <= w_hi;
            r_lo <= w_lo;
            if (r_cnt == '0) begin
              r_state     <= ST_DONE;
              r_result    <= w_final;
              r_out_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
